// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory load/store controller.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && ofs[0]) ||
               (size == SZ_WORD && ofs != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline request/response plus word-wide data memory bus.
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane extract/extend for loads and byte/half merge for stores.
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_ofs,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_word
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = i_word[{i_ofs, 3'b000} +: 8];
        w_half    = i_word[{i_ofs[1], 4'b0000} +: 16];
        o_ld_data = i_word;
        o_st_word = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_ld_data = {{24{i_signed & w_byte[7]}}, w_byte};
                o_st_word[{i_ofs, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_ld_data = {{16{i_signed & w_half[15]}}, w_half};
                o_st_word[{i_ofs[1], 4'b0000} +: 16] = i_wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: alignment checks, lane extract, sub-word RMW.
module dmem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int MEM_ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_access_ctrl_if.slave  bus
);
    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_accept, w_err;
    logic        w_rsp_valid_nxt, w_rsp_err_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic [31:0] w_ld_data, w_st_word;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    assign w_err    = misaligned(bus.req_size, bus.req_addr[1:0]) ||
                      (|bus.req_addr[31:MEM_ADDR_W]);

    dmem_lane_align u_align (
        .i_word    (bus.mem_rdata),
        .i_ofs     (r_addr[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld_data),
        .o_st_word (w_st_word)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (!bus.req_we) begin
                        w_state_nxt = ST_LOAD;
                    end else if (bus.req_size == SZ_WORD) begin
                        w_state_nxt = ST_STORE;
                    end else begin
                        w_state_nxt = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = w_ld_data;
                w_state_nxt     = ST_IDLE;
            end
            ST_RMW_RD: w_state_nxt = ST_RMW_WR;
            ST_STORE, ST_RMW_WR: begin
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            if (w_accept) begin
                r_addr   <= bus.req_addr;
                r_size   <= bus.req_size;
                r_signed <= bus.req_signed;
                r_wdata  <= bus.req_wdata[15:0];
                if (bus.req_we)
                    r_mem_wdata <= bus.req_wdata;
            end
            // Merged word is captured while the old word is on mem_rdata.
            if (r_state == ST_RMW_RD)
                r_mem_wdata <= w_st_word;
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_read  = (r_state == ST_LOAD) || (r_state == ST_RMW_RD);
    assign bus.mem_write = (r_state == ST_STORE) || (r_state == ST_RMW_WR);
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = r_mem_wdata;
endmodule
